// File: rtl/dist_seq_pkg.sv
// Shared types and widths for the per-angle-step shot sequencer.
package dist_seq_pkg;

   localparam int unsigned ANGLE_W = 16;
   localparam int unsigned ECHO_N  = 5;
   localparam int unsigned DIST_W  = 16 * ECHO_N;
   localparam int unsigned PLUSE_W = 8 * ECHO_N;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG,
      S_FIRE,
      S_CAPTURE,
      S_PROCESS,
      S_OUTPUT
   } state_t;

endpackage

// File: rtl/shot_timer.sv
// Loadable up-counter with a compare-to-limit expiry flag, shared by all timed states.
module shot_timer #(
   parameter int unsigned CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] limit,
   output logic             expired,
   output logic             first
);

   logic [CNT_W-1:0] count;

   // Saturates so a long stay in an untimed state cannot wrap into a false match.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == limit);
   assign first   = (count == '0);

endmodule

// File: rtl/shot_sequencer.sv
// Per-angle-step controller: fire, capture, launch processing, buffer result, grant cfg windows.
module shot_sequencer
   import dist_seq_pkg::*;
#(
   parameter int unsigned FIRE_W       = 4,
   parameter int unsigned CAP_TIMEOUT  = 64,
   parameter int unsigned PROC_TIMEOUT = 1024,
   parameter int unsigned ANGLE_W      = dist_seq_pkg::ANGLE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run_en,
   input  logic               zero_tick,
   input  logic               angle_tick,
   output logic               laser_fire,
   output logic               cap_start,
   input  logic               cap_done,
   output logic               tola_en,
   input  logic               res_strobe,
   input  logic               target_valid,
   input  logic [DIST_W-1:0]  mult_distance,
   input  logic [PLUSE_W-1:0] mult_pluse,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIST_W-1:0]  out_distance,
   output logic [PLUSE_W-1:0] out_pluse,
   output logic               out_target,
   output logic               out_timeout,
   output logic [ANGLE_W-1:0] out_angle,
   input  logic               cfg_req,
   output logic               cfg_grant,
   output logic               busy,
   output logic [15:0]        miss_cnt
);

   localparam int unsigned TMR_MAX = (PROC_TIMEOUT > CAP_TIMEOUT) ?
                                     ((PROC_TIMEOUT > FIRE_W) ? PROC_TIMEOUT : FIRE_W) :
                                     ((CAP_TIMEOUT > FIRE_W) ? CAP_TIMEOUT : FIRE_W);
   localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

   state_t             state, state_next;
   logic               pending, consume;
   logic [ANGLE_W-1:0] angle_idx, tick_angle, shot_angle;
   logic [TMR_W-1:0]   limit;
   logic               t_expired, t_first;

   shot_timer #(.CNT_W(TMR_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (state_next != state),
      .limit   (limit),
      .expired (t_expired),
      .first   (t_first)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      limit      = '1;
      laser_fire = 1'b0;
      cap_start  = 1'b0;
      consume    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_req) begin
               state_next = S_CFG;
            end else if (run_en && pending) begin
               state_next = S_FIRE;
               consume    = 1'b1;
            end
         end
         S_CFG: if (!cfg_req) state_next = S_IDLE;
         S_FIRE: begin
            limit      = TMR_W'(FIRE_W - 1);
            laser_fire = 1'b1;
            cap_start  = t_first;
            if (t_expired) state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            limit = TMR_W'(CAP_TIMEOUT - 1);
            if (cap_done || t_expired) state_next = cap_done ? S_PROCESS : S_OUTPUT;
         end
         S_PROCESS: begin
            limit = TMR_W'(PROC_TIMEOUT - 1);
            if (res_strobe || t_expired) state_next = S_OUTPUT;
         end
         S_OUTPUT: if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign out_valid = (state == S_OUTPUT);
   assign cfg_grant = (state == S_CFG);
   assign busy      = (state != S_IDLE) && (state != S_CFG);

   always_ff @(posedge clk) begin
      if (rst) begin
         angle_idx    <= '0;
         tick_angle   <= '0;
         shot_angle   <= '0;
         pending      <= 1'b0;
         miss_cnt     <= '0;
         tola_en      <= 1'b0;
         out_distance <= '0;
         out_pluse    <= '0;
         out_target   <= 1'b0;
         out_timeout  <= 1'b0;
         out_angle    <= '0;
      end else begin
         tola_en <= (state == S_CAPTURE) && cap_done;

         if (zero_tick)       angle_idx <= '0;
         else if (angle_tick) angle_idx <= angle_idx + 1'b1;

         // A tick in the consume cycle re-arms pending; only a tick onto an unconsumed one is a miss.
         if (angle_tick) begin
            pending    <= 1'b1;
            tick_angle <= zero_tick ? '0 : angle_idx + 1'b1;
            if (pending && !consume && (miss_cnt != '1)) miss_cnt <= miss_cnt + 16'd1;
         end else if (consume) begin
            pending <= 1'b0;
         end

         if (consume) shot_angle <= tick_angle;

         if ((state == S_CAPTURE) && !cap_done && t_expired) begin
            out_distance <= '0;
            out_pluse    <= '0;
            out_target   <= 1'b0;
            out_timeout  <= 1'b1;
            out_angle    <= shot_angle;
         end else if ((state == S_PROCESS) && (res_strobe || t_expired)) begin
            out_distance <= res_strobe ? mult_distance : '0;
            out_pluse    <= res_strobe ? mult_pluse : '0;
            out_target   <= res_strobe && target_valid;
            out_timeout  <= !res_strobe;
            out_angle    <= shot_angle;
         end
      end
   end

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer with hand-computed expectations.
module tb_shot_sequencer;

   localparam int unsigned FIRE_W       = 4;
   localparam int unsigned CAP_TIMEOUT  = 64;
   localparam int unsigned PROC_TIMEOUT = 1024;
   localparam int unsigned ANGLE_W      = 16;

   localparam logic [79:0] D1 = 80'h0001_0002_0003_0004_0005;
   localparam logic [39:0] P1 = 40'h11_22_33_44_55;
   localparam logic [79:0] D2 = 80'hA0A0_B1B1_C2C2_D3D3_E4E4;
   localparam logic [39:0] P2 = 40'h01_02_03_04_05;
   localparam logic [79:0] D3 = 80'h1234_5678_9ABC_DEF0_0F0F;
   localparam logic [39:0] P3 = 40'hFE_DC_BA_98_76;

   logic               clk = 1'b0;
   logic               rst, run_en, zero_tick, angle_tick, cap_done, res_strobe, target_valid;
   logic               out_ready, cfg_req;
   logic [79:0]        mult_distance;
   logic [39:0]        mult_pluse;
   logic               laser_fire, cap_start, tola_en, out_valid, out_target, out_timeout;
   logic               cfg_grant, busy;
   logic [79:0]        out_distance;
   logic [39:0]        out_pluse;
   logic [ANGLE_W-1:0] out_angle;
   logic [15:0]        miss_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic        seen_tola;

   shot_sequencer #(
      .FIRE_W       (FIRE_W),
      .CAP_TIMEOUT  (CAP_TIMEOUT),
      .PROC_TIMEOUT (PROC_TIMEOUT),
      .ANGLE_W      (ANGLE_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .run_en        (run_en),
      .zero_tick     (zero_tick),
      .angle_tick    (angle_tick),
      .laser_fire    (laser_fire),
      .cap_start     (cap_start),
      .cap_done      (cap_done),
      .tola_en       (tola_en),
      .res_strobe    (res_strobe),
      .target_valid  (target_valid),
      .mult_distance (mult_distance),
      .mult_pluse    (mult_pluse),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_distance  (out_distance),
      .out_pluse     (out_pluse),
      .out_target    (out_target),
      .out_timeout   (out_timeout),
      .out_angle     (out_angle),
      .cfg_req       (cfg_req),
      .cfg_grant     (cfg_grant),
      .busy          (busy),
      .miss_cnt      (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tick();
      angle_tick = 1'b1;
      step();
      angle_tick = 1'b0;
   endtask

   // Ends in the first PROCESS cycle of a fresh shot.
   task automatic to_process();
      pulse_tick();
      step(1 + FIRE_W);
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
   endtask

   // Ends in the first OUTPUT cycle.
   task automatic give_result(input logic [79:0] d, input logic [39:0] p, input logic t);
      res_strobe    = 1'b1;
      mult_distance = d;
      mult_pluse    = p;
      target_valid  = t;
      step();
      res_strobe    = 1'b0;
      mult_distance = '0;
      mult_pluse    = '0;
      target_valid  = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; run_en = 1'b1; zero_tick = 1'b0; angle_tick = 1'b0; cap_done = 1'b0;
      res_strobe = 1'b0; target_valid = 1'b0; out_ready = 1'b0; cfg_req = 1'b0;
      mult_distance = '0; mult_pluse = '0;
      step(2);
      check("rst_ctl", 128'({laser_fire, cap_start, tola_en, out_valid, cfg_grant, busy, out_target, out_timeout}), 128'(0));
      check("rst_data", 128'({out_distance, out_pluse}), 128'(0));
      check("rst_angle_miss", 128'({out_angle, miss_cnt}), 128'(0));
      rst = 1'b0;
      step();

      // Basic shot: tick during cycle c, FIRE during c+2..c+5, cap_done at c+20, result at c+50
      pulse_tick();
      check("basic_pend_no_fire", 128'(laser_fire), 128'(0));
      step();
      check("basic_fire0", 128'({laser_fire, cap_start, busy}), 128'(3'b111));
      for (int i = 0; i < 3; i++) begin
         step();
         check("basic_fire_n", 128'({laser_fire, cap_start}), 128'(2'b10));
      end
      step();
      check("basic_capture_entry", 128'({laser_fire, busy}), 128'(2'b01));
      step(14);
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
      check("basic_tola", 128'(tola_en), 128'(1));
      step();
      check("basic_tola_one", 128'(tola_en), 128'(0));
      step(28);
      check("basic_not_valid", 128'(out_valid), 128'(0));
      give_result(D1, P1, 1'b1);
      check("basic_valid", 128'({out_valid, out_timeout, out_target}), 128'(3'b101));
      check("basic_dist", 128'(out_distance), 128'(D1));
      check("basic_pluse", 128'(out_pluse), 128'(P1));
      check("basic_angle", 128'(out_angle), 128'(1));

      // Backpressure
      for (int i = 0; i < 100; i++) begin
         step();
         check("bp_hold", 128'({out_valid, out_timeout, out_target, out_angle, out_distance}),
               {1'b1, 1'b0, 1'b1, 16'd1, D1});
      end
      handshake();
      check("basic_drop", 128'({out_valid, busy}), 128'(0));

      // Capture timeout
      seen_tola = 1'b0;
      pulse_tick();
      step(1 + FIRE_W);
      for (int i = 0; i < 63; i++) begin
         step();
         seen_tola = seen_tola | tola_en;
      end
      check("capto_wait", 128'({out_valid, busy}), 128'(2'b01));
      step();
      check("capto_valid", 128'({out_valid, out_timeout, out_target}), 128'(3'b110));
      check("capto_data", 128'({out_distance, out_pluse}), 128'(0));
      check("capto_angle", 128'(out_angle), 128'(2));
      check("capto_no_tola", 128'(seen_tola | tola_en), 128'(0));
      handshake();

      // Misses: three ticks during PROCESS
      to_process();
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         step(4);
      end
      check("miss_cnt2", 128'(miss_cnt), 128'(2));
      give_result(D2, P2, 1'b0);
      check("miss_shot_angle", 128'(out_angle), 128'(3));
      handshake();
      check("miss_idle", 128'(laser_fire), 128'(0));
      step();
      check("miss_refire", 128'({laser_fire, cap_start}), 128'(2'b11));
      step(FIRE_W);
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
      give_result(D3, P3, 1'b1);
      check("miss_third_angle", 128'(out_angle), 128'(6));
      check("miss_third_dist", 128'(out_distance), 128'(D3));
      handshake();

      // Config window requested during PROCESS
      to_process();
      cfg_req = 1'b1;
      pulse_tick();
      check("cfg_proc_nogrant", 128'(cfg_grant), 128'(0));
      give_result(D1, P1, 1'b0);
      check("cfg_out_angle", 128'(out_angle), 128'(7));
      step(2);
      check("cfg_out_nogrant", 128'({cfg_grant, out_valid}), 128'(2'b01));
      handshake();
      check("cfg_idle", 128'({cfg_grant, busy}), 128'(0));
      step();
      check("cfg_grant", 128'({cfg_grant, busy, laser_fire}), 128'(3'b100));
      pulse_tick();
      check("cfg_miss", 128'(miss_cnt), 128'(3));
      step(4);
      check("cfg_hold", 128'({cfg_grant, laser_fire}), 128'(2'b10));
      cfg_req = 1'b0;
      step();
      check("cfg_release", 128'({cfg_grant, laser_fire}), 128'(0));
      step();
      check("cfg_then_fire", 128'({laser_fire, cap_start}), 128'(2'b11));

      // Result on the PROC_TIMEOUT expiry cycle wins
      step(FIRE_W);
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
      step(PROC_TIMEOUT - 1);
      check("proc_edge_wait", 128'({out_valid, busy}), 128'(2'b01));
      give_result(D2, P2, 1'b1);
      check("proc_edge_result", 128'({out_valid, out_timeout, out_target}), 128'(3'b101));
      check("proc_edge_data", 128'({out_distance, out_pluse}), {8'h0, D2, P2});
      check("proc_edge_angle", 128'(out_angle), 128'(9));
      handshake();

      // zero_tick coincident with angle_tick
      zero_tick = 1'b1;
      angle_tick = 1'b1;
      step();
      zero_tick = 1'b0;
      angle_tick = 1'b0;
      step(1 + FIRE_W);
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
      give_result(D3, P3, 1'b0);
      check("zero_angle", 128'(out_angle), 128'(0));
      handshake();

      // run_en=0 holds pending, then mid-shot reset
      run_en = 1'b0;
      pulse_tick();
      step(5);
      check("run_off_hold", 128'({laser_fire, busy}), 128'(0));
      run_en = 1'b1;
      step();
      check("run_on_fire", 128'(laser_fire), 128'(1));
      step(FIRE_W);
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
      pulse_tick();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_ctl", 128'({laser_fire, cap_start, tola_en, out_valid, cfg_grant, busy, out_target, out_timeout}), 128'(0));
      check("rst_mid_data", 128'({out_distance, out_pluse}), 128'(0));
      check("rst_mid_angle_miss", 128'({out_angle, miss_cnt}), 128'(0));
      step(5);
      check("rst_pending_clear", 128'({laser_fire, busy}), 128'(0));
      cap_done = 1'b1;
      step();
      cap_done = 1'b0;
      check("stray_cap_done", 128'({tola_en, busy}), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
